// File: rtl/store_pkg.sv
// Shared encodings and entry record for the store narrowing buffer.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Entry addresses are held at this width and resized at the module boundary.
    localparam int ENTRY_ADDR_W = 32;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [31:0]             wdata;
        logic [3:0]              be;
    } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Narrows register data onto byte lanes, builds byte enables, and flags misaligned stores.
module store_lane_align
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    output logic [3:0]        be,
    output logic              bad
);

    // Lane replication and enable generation per access size.
    always_comb begin
        addr  = {st_addr[ADDR_W-1:2], 2'b00};
        wdata = 32'h0000_0000;
        be    = 4'b0000;
        bad   = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                wdata = {4{st_data[7:0]}};
                be    = 4'b0001 << st_addr[1:0];
            end
            SZ_HALF: begin
                wdata = {2{st_data[15:0]}};
                be    = st_addr[1] ? 4'b1100 : 4'b0011;
                bad   = st_addr[0];
            end
            SZ_WORD: begin
                wdata = st_data;
                be    = 4'b1111;
                bad   = (st_addr[1:0] != 2'b00);
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buf.sv
// Store buffer: aligns core stores, queues them, and drains to memory over req/ack.
// Optional macro STORE_MERGE_EN merges same-word stores into the tail entry.
module store_narrow_buf
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     misalign,
    output logic                     buf_empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] al_addr_s;
    logic [31:0]       al_wdata_s;
    logic [3:0]        al_be_s;
    logic              al_bad_s;

    entry_t            fifo_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  tail_s;
    logic [PTR_W-1:0]  next_rd_s;
    logic [CNT_W-1:0]  count_r;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              mem_req_r;
    logic              req_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [3:0]        mem_be_r;
    logic              misalign_r;

    logic              load_s;
    entry_t            load_entry_s;
    entry_t            new_entry_s;
    entry_t            merged_s;
    logic              full_s;
    logic              merge_ok_s;
    logic              acc_s;
    logic              push_s;
    logic              merge_s;
    logic              pop_s;

    store_lane_align #(.ADDR_W(ADDR_W)) u_align (
        .st_addr (st_addr),
        .st_data (st_data),
        .st_size (st_size),
        .addr    (al_addr_s),
        .wdata   (al_wdata_s),
        .be      (al_be_s),
        .bad     (al_bad_s)
    );

    assign new_entry_s = '{addr: ENTRY_ADDR_W'(al_addr_s), wdata: al_wdata_s, be: al_be_s};
    assign tail_s      = wr_ptr_r - PTR_W'(1);
    assign next_rd_s   = rd_ptr_r + PTR_W'(1);
    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign pop_s       = mem_req_r && mem_ack;

`ifdef STORE_MERGE_EN
    // The tail may merge only if it is neither on mem_* nor about to be loaded there.
    always_comb begin
        merge_ok_s = 1'b0;
        if ((count_r > (pop_s ? CNT_W'(2) : CNT_W'(1))) && !al_bad_s &&
            (fifo_r[tail_s].addr == ENTRY_ADDR_W'(al_addr_s))) begin
            merge_ok_s = 1'b1;
        end else begin
            merge_ok_s = 1'b0;
        end
    end
`else
    assign merge_ok_s = 1'b0;
`endif

    assign st_ready = !full_s || merge_ok_s;
    assign acc_s    = st_valid && st_ready;
    assign push_s   = acc_s && !al_bad_s && !merge_ok_s;
    assign merge_s  = acc_s && !al_bad_s && merge_ok_s;

    // Byte-wise overlay of the incoming store onto the tail entry.
    always_comb begin
        merged_s      = fifo_r[tail_s];
        merged_s.be   = fifo_r[tail_s].be | al_be_s;
        for (int i = 0; i < 4; i++) begin
            if (al_be_s[i]) begin
                merged_s.wdata[8*i +: 8] = al_wdata_s[8*i +: 8];
            end else begin
                merged_s.wdata[8*i +: 8] = fifo_r[tail_s].wdata[8*i +: 8];
            end
        end
    end

    // Drain FSM next state; an empty-buffer push bypasses straight onto mem_*.
    always_comb begin
        state_nxt_s  = state_r;
        req_nxt_s    = mem_req_r;
        load_s       = 1'b0;
        load_entry_s = '0;
        case (state_r)
            S_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    load_s       = 1'b1;
                    load_entry_s = fifo_r[rd_ptr_r];
                    req_nxt_s    = 1'b1;
                    state_nxt_s  = S_REQ;
                end else if (push_s) begin
                    load_s       = 1'b1;
                    load_entry_s = new_entry_s;
                    req_nxt_s    = 1'b1;
                    state_nxt_s  = S_REQ;
                end else begin
                    req_nxt_s    = 1'b0;
                    state_nxt_s  = S_IDLE;
                end
            end
            S_REQ: begin
                if (pop_s) begin
                    if (count_r > CNT_W'(1)) begin
                        load_s       = 1'b1;
                        load_entry_s = fifo_r[next_rd_s];
                    end else if (push_s) begin
                        load_s       = 1'b1;
                        load_entry_s = new_entry_s;
                    end else begin
                        req_nxt_s    = 1'b0;
                        state_nxt_s  = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            default: begin
                req_nxt_s   = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state and memory-port registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            misalign_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mem_req_r  <= req_nxt_s;
            misalign_r <= acc_s && al_bad_s;
            if (load_s) begin
                mem_addr_r  <= ADDR_W'(load_entry_s.addr);
                mem_wdata_r <= load_entry_s.wdata;
                mem_be_r    <= load_entry_s.be;
            end
        end
    end

    // Entry storage, pointers and occupancy; the head stays counted until acked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end else if (merge_s) begin
                fifo_r[tail_s] <= merged_s;
            end
            if (pop_s) begin
                rd_ptr_r <= next_rd_s;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign misalign  = misalign_r;
    assign count     = count_r;
    assign buf_empty = (count_r == CNT_W'(0)) && !mem_req_r;

endmodule
